bus_responder: RTL
==================

Name: bus_responder

Overview:
- Bus-side responder at the far end of the memory-controller bus interface.
- Accepts one read or write request at a time from the memory controller.
- Models a word-addressed memory with a fixed number of wait states.
- Drives the busy indication the controller samples as bus_full, and returns read data plus a completion strobe.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the backing array (power of two, ≥ 4)
WAIT_CYCLES, 2, extra busy cycles inserted before each access completes (0–15)
ERR_DATA, 32'hBAD0_BAD0, value returned on a faulted read

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset, asynchronous, active-high
address_in  in  32  byte address from the controller
data_in  in  32  write data from the controller
read_req  in  1  read request, level, sampled only in IDLE
write_req  in  1  write request, level, sampled only in IDLE
data_out  out  32  read data, registered
busy  out  1  responder busy; connects to the controller's bus_full
data_valid  out  1  one-cycle completion strobe, for reads and writes
error  out  1  fault flag, qualified by data_valid
state  out  3  current FSM state, for debug and bench checking

Behaviour:
Interface:
- Single clock clk.
- rst is asynchronous and active-high.

Reset values:
- state=IDLE, busy=0, data_valid=0, error=0, data_out=0, wait counter=0.
- Every word of the backing array is cleared to 0.
- Reset asserted mid-transaction aborts it immediately:
  - A pending write is not committed.
  - No data_valid is produced.

States (3-bit encoding): IDLE=0, BUSY=1, DONE=2; codes 3–7 are illegal and recover to IDLE.

IDLE:
- On a rising edge with read_req|write_req=1:
  - Latch address_in, data_in and the op (read wins when both are high).
  - Load counter=WAIT_CYCLES, go to BUSY, set busy=1.
- With no request, remain in IDLE with busy=0.

BUSY:
- Requests are ignored.
- While counter!=0, decrement it each edge.
- On the edge where counter==0, perform the access, then go to DONE with busy=0, data_valid=1.

DONE:
- Lasts exactly one cycle, then returns to IDLE with data_valid=0.
- A request present during DONE is not sampled; it is sampled on the following IDLE edge.

Timing (request sampled at edge k):
- busy is high from k to k+WAIT_CYCLES+1, i.e. WAIT_CYCLES+1 cycles.
- data_valid is high for the single cycle after edge k+WAIT_CYCLES+1.
- Minimum request-to-request spacing is WAIT_CYCLES+3 edges.

Read access:
- data_out = array[index], where index = latched address[log2(DEPTH_WORDS)+1:2].
- data_out holds its value until the next read completes; writes do not change it.

Write access:
- array[index] = latched data_in.

Faults:
- A fault is either a misaligned address (address[1:0]!=0) or address ≥ 4*DEPTH_WORDS.
- On a fault: error=1 with data_valid, no array write, and a read returns ERR_DATA.
- error clears together with data_valid.

Other rules:
- Request inputs are don't-care outside IDLE.
- Inputs are latched at acceptance; later changes to them do not affect the transaction in flight.

Decomposition:
- Package bus_responder_pkg:
  - typedef enum logic [2:0] resp_state_t {IDLE, BUSY, DONE}.
  - ERR_DATA default constant.
- Sub-module bus_mem_array:
  - Synchronous-write, registered-read word array.
  - Async reset clear; ports clk, rst, we, re, index, wdata, rdata.
- FSM, counter, latch and fault decode stay in bus_responder.

Test Plan:
1. Power-on: rst=1 for 2 cycles with read_req=1, address_in=4 → state=IDLE, busy=0, data_valid=0, data_out=0. Release rst → next edge BUSY, busy=1.
2. Write then read (WAIT_CYCLES=2): write_req=1, address_in=8, data_in=32'h1234_5678 → busy high 3 cycles, then data_valid=1, error=0. Then read_req=1, address_in=8 → after 3 busy cycles, data_valid=1, data_out=32'h1234_5678.
3. Simultaneous read_req=write_req=1 at address 8 (holding 32'h1234_5678) with data_in=32'hFFFF_FFFF → read performed, data_out=32'h1234_5678. A follow-up read confirms the word is unchanged.
4. Faults:
   - write address_in=6 → data_valid=1, error=1; a read of word 4 is still 0.
   - read address_in=4*DEPTH_WORDS (1024) → data_out=32'hBAD0_BAD0, error=1.
5. Requests held continuously high → exactly one data_valid per WAIT_CYCLES+3 cycles. Changing address_in during BUSY does not alter the transaction in flight.
6. Reset mid-write: assert rst asynchronously during BUSY of a write of 32'hAAAA_AAAA to address 12 → immediately IDLE, busy=0. A subsequent read of 12 returns 0, and no data_valid is produced for the aborted write.

Source files
------------

// File: rtl/bus_responder_pkg.sv
// Shared types and constants for the bus responder and its word array.
package bus_responder_pkg;

    // Responder FSM states; codes 3..7 are illegal and fall back to IDLE.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BUSY = 3'd1,
        DONE = 3'd2
    } resp_state_t;

    // Value returned when a read hits a faulted address.
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBAD0_BAD0;

    // Width of the wait-state counter (WAIT_CYCLES is limited to 0..15).
    localparam int CNT_W = 4;

    // A byte address faults when it is not word aligned or lies past the
    // end of a 2**idx_w word array.
    function automatic logic addr_fault(input logic [31:0] addr, input int idx_w);
        addr_fault = (addr[1:0] != 2'b00) || ((addr >> (idx_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Word array behind the responder: synchronous write, registered read,
// whole array cleared by reset.
module bus_mem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] index,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Write port, registered read port and reset clear of every word.
    // NOTE: clearing every word in reset makes this a flop array rather than
    // an inferred RAM; the zero-after-reset contents are part of the behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[index] <= wdata;
            end
            if (re) begin
                rdata <= mem[index];
            end
        end
    end

endmodule

// File: rtl/bus_responder.sv
// Bus-side responder: accepts one read or write at a time, holds busy for
// WAIT_CYCLES+1 cycles, then completes with a one-cycle data_valid strobe.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address_in,
    input  logic [31:0] data_in,
    input  logic        read_req,
    input  logic        write_req,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        data_valid,
    output logic        error,
    output logic [2:0]  state
);

    localparam int               IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    resp_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             rd_q;
    logic             err_sel_q;

    logic             accept;
    logic             count_down;
    logic             complete;
    logic             fault;
    logic             mem_we;
    logic             mem_re;
    logic [31:0]      mem_rdata;

    assign fault  = addr_fault(addr_q, IDX_W);
    assign mem_we = complete && !rd_q && !fault;
    assign mem_re = complete &&  rd_q && !fault;

    // State register; reset aborts any transaction in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-cycle control strobes.
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        count_down = 1'b0;
        complete   = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_req || write_req) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    complete = 1'b1;
                    state_d  = DONE;
                end else begin
                    count_down = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch, wait-state counter and read-fault select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            err_sel_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= address_in;
                wdata_q <= data_in;
                rd_q    <= read_req;
                cnt_q   <= WAIT_LOAD;
            end else if (count_down) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            // Only a completing read changes what data_out shows.
            if (complete && rd_q) begin
                err_sel_q <= fault;
            end
        end
    end

    bus_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .index (addr_q[IDX_W+1:2]),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign data_out   = err_sel_q ? ERR_DATA : mem_rdata;
    assign busy       = (state_q == BUSY);
    assign data_valid = (state_q == DONE);
    assign error      = data_valid && fault;
    assign state      = state_q;

endmodule
